// File: rtl/fault_recovery_if.sv
// Fault recovery interface: bundles the classifier-side inputs and the
// recovery controller's status/control outputs.
//   fault_type     classifier output (00 none, 01 minor, 1x critical)
//   fault_clear    operator acknowledge pulse, acts only while halted
//   pipeline_flush flush all in-flight instructions
//   pipeline_stall freeze fetch/PC
//   retry_req      one-cycle re-fetch request
//   cpu_halt       CPU held in safe halt
//   rec_state      current controller state (debug)
//   retry_cnt      minor recoveries in the current episode
//   minor_events   saturating count of accepted minor faults
//   crit_events    saturating count of critical faults and escalations
// Modports: master = classifier/operator side, slave = recovery controller.
interface fault_recovery_if #(
    parameter int MAX_RETRIES = 3,
    parameter int CNT_W       = 8
) ();
    localparam int RC_W = ($clog2(MAX_RETRIES + 1) < 2) ? 2 : $clog2(MAX_RETRIES + 1);

    logic [1:0]       fault_type;
    logic             fault_clear;
    logic             pipeline_flush;
    logic             pipeline_stall;
    logic             retry_req;
    logic             cpu_halt;
    logic [2:0]       rec_state;
    logic [RC_W-1:0]  retry_cnt;
    logic [CNT_W-1:0] minor_events;
    logic [CNT_W-1:0] crit_events;

    modport master (
        output fault_type, fault_clear,
        input  pipeline_flush, pipeline_stall, retry_req, cpu_halt,
        input  rec_state, retry_cnt, minor_events, crit_events
    );

    modport slave (
        input  fault_type, fault_clear,
        output pipeline_flush, pipeline_stall, retry_req, cpu_halt,
        output rec_state, retry_cnt, minor_events, crit_events
    );
endinterface

// File: rtl/fault_recovery_fsm.sv
// Fault recovery controller. Consumes the classifier's fault_type every cycle
// and sequences the CPU response: a minor fault triggers flush -> retry ->
// clean-run monitor window; a critical fault, or one minor fault too many,
// latches a safe halt that only an acknowledge with no active fault releases.
// Saturating event counters are kept for status/debug.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    fault_recovery_if.slave (fault inputs, control/status outputs)
// All outputs are registered: an event sampled at edge k is visible after edge k.
module fault_recovery_fsm #(
    parameter int FLUSH_CYCLES = 3,
    parameter int MAX_RETRIES  = 3,
    parameter int CLEAN_WINDOW = 16,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    fault_recovery_if.slave   bus
);
    localparam int RC_W = ($clog2(MAX_RETRIES + 1) < 2) ? 2 : $clog2(MAX_RETRIES + 1);
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int WC_W = (CLEAN_WINDOW > 1) ? $clog2(CLEAN_WINDOW) : 1;

    localparam logic [RC_W-1:0] RETRY_MAX  = RC_W'(MAX_RETRIES);
    localparam logic [RC_W-1:0] RC_ONE     = RC_W'(1);
    localparam logic [RC_W-1:0] RC_ZERO    = RC_W'(0);
    localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [FC_W-1:0] FC_ONE     = FC_W'(1);
    localparam logic [FC_W-1:0] FC_ZERO    = FC_W'(0);
    localparam logic [WC_W-1:0] WIN_LAST   = WC_W'(CLEAN_WINDOW - 1);
    localparam logic [WC_W-1:0] WC_ONE     = WC_W'(1);
    localparam logic [WC_W-1:0] WC_ZERO    = WC_W'(0);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b000,
        ST_FLUSH   = 3'b001,
        ST_RETRY   = 3'b010,
        ST_MONITOR = 3'b011,
        ST_HALT    = 3'b100
    } state_t;

    // Control output bundle order: {flush, stall, retry_req, halt}
    function automatic logic [3:0] decode_ctrl(input state_t s);
        logic [3:0] ctrl;
        case (s)
            ST_FLUSH: ctrl = 4'b1100;
            ST_RETRY: ctrl = 4'b0010;
            ST_HALT:  ctrl = 4'b0101;
            default:  ctrl = 4'b0000;
        endcase
        return ctrl;
    endfunction

    // Event counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        logic [CNT_W-1:0] r;
        if (inc && (v != CNT_MAX)) begin
            r = v + CNT_ONE;
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [FC_W-1:0]  flush_cnt_r;
    logic [FC_W-1:0]  flush_cnt_s;
    logic [WC_W-1:0]  win_cnt_r;
    logic [WC_W-1:0]  win_cnt_s;
    logic [RC_W-1:0]  retry_cnt_r;
    logic [RC_W-1:0]  retry_cnt_s;
    logic [CNT_W-1:0] minor_cnt_r;
    logic [CNT_W-1:0] crit_cnt_r;
    logic             minor_inc_s;
    logic             crit_inc_s;
    logic             flush_r;
    logic             stall_r;
    logic             retry_req_r;
    logic             halt_r;
    logic [3:0]       ctrl_s;

    logic             crit_s;
    logic             minor_s;
    logic             quiet_s;

    assign crit_s  = bus.fault_type[1];
    assign minor_s = (bus.fault_type == 2'b01);
    assign quiet_s = (bus.fault_type == 2'b00);

    // Next-state, episode counters and event-increment decisions.
    always_comb begin
        state_s     = state_r;
        flush_cnt_s = flush_cnt_r;
        win_cnt_s   = win_cnt_r;
        retry_cnt_s = retry_cnt_r;
        minor_inc_s = 1'b0;
        crit_inc_s  = 1'b0;
        case (state_r)
            ST_IDLE, ST_MONITOR: begin
                if (crit_s) begin
                    state_s    = ST_HALT;
                    crit_inc_s = 1'b1;
                end else if (minor_s) begin
                    minor_inc_s = 1'b1;
                    if (retry_cnt_r < RETRY_MAX) begin
                        state_s     = ST_FLUSH;
                        retry_cnt_s = retry_cnt_r + RC_ONE;
                        flush_cnt_s = FC_ZERO;
                    end else begin
                        // Retry budget exhausted: escalate as a critical event.
                        state_s    = ST_HALT;
                        crit_inc_s = 1'b1;
                    end
                end else if (state_r == ST_MONITOR) begin
                    if (win_cnt_r == WIN_LAST) begin
                        state_s     = ST_IDLE;
                        retry_cnt_s = RC_ZERO;
                        win_cnt_s   = WC_ZERO;
                    end else begin
                        win_cnt_s = win_cnt_r + WC_ONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                // Minor faults here belong to instructions being discarded.
                if (crit_s) begin
                    state_s    = ST_HALT;
                    crit_inc_s = 1'b1;
                end else if (flush_cnt_r == FLUSH_LAST) begin
                    state_s     = ST_RETRY;
                    flush_cnt_s = FC_ZERO;
                end else begin
                    flush_cnt_s = flush_cnt_r + FC_ONE;
                end
            end
            ST_RETRY: begin
                if (crit_s) begin
                    state_s    = ST_HALT;
                    crit_inc_s = 1'b1;
                end else begin
                    state_s   = ST_MONITOR;
                    win_cnt_s = WC_ZERO;
                end
            end
            ST_HALT: begin
                if (bus.fault_clear && quiet_s) begin
                    state_s     = ST_IDLE;
                    retry_cnt_s = RC_ZERO;
                    flush_cnt_s = FC_ZERO;
                    win_cnt_s   = WC_ZERO;
                end else begin
                    state_s = ST_HALT;
                end
            end
            default: begin
                state_s = ST_HALT;
            end
        endcase
    end

    // Control outputs are decoded from the next state so they register with it.
    always_comb begin
        ctrl_s = decode_ctrl(state_s);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            flush_cnt_r <= FC_ZERO;
            win_cnt_r   <= WC_ZERO;
            retry_cnt_r <= RC_ZERO;
            minor_cnt_r <= CNT_ZERO;
            crit_cnt_r  <= CNT_ZERO;
            flush_r     <= 1'b0;
            stall_r     <= 1'b0;
            retry_req_r <= 1'b0;
            halt_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            flush_cnt_r <= flush_cnt_s;
            win_cnt_r   <= win_cnt_s;
            retry_cnt_r <= retry_cnt_s;
            minor_cnt_r <= sat_inc(minor_cnt_r, minor_inc_s);
            crit_cnt_r  <= sat_inc(crit_cnt_r, crit_inc_s);
            flush_r     <= ctrl_s[3];
            stall_r     <= ctrl_s[2];
            retry_req_r <= ctrl_s[1];
            halt_r      <= ctrl_s[0];
        end
    end

    assign bus.pipeline_flush = flush_r;
    assign bus.pipeline_stall = stall_r;
    assign bus.retry_req      = retry_req_r;
    assign bus.cpu_halt       = halt_r;
    assign bus.rec_state      = state_r;
    assign bus.retry_cnt      = retry_cnt_r;
    assign bus.minor_events   = minor_cnt_r;
    assign bus.crit_events    = crit_cnt_r;
endmodule
